// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tap-stream interface (transmit and receive ends).
package conv_pkg;

    localparam int unsigned CONV_DATA_W = 8;
    localparam int unsigned CONV_TAPS   = 9;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_e;

endpackage

// File: rtl/tap_cnt.sv
// Modulo-TAPS tap counter; clr has priority over inc and returns the count to 0.
module tap_cnt
    import conv_pkg::*;
#(
    parameter int unsigned TAPS = CONV_TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(TAPS)-1:0]  cnt,
    output logic                     at_last
);

    localparam int unsigned CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/conv_win_tx.sv
// Window serializer: captures a flat TAPS-tap window and streams it one tap per accepted beat.
module conv_win_tx
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = CONV_DATA_W,
    parameter int unsigned TAPS   = CONV_TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [TAPS*DATA_W-1:0]   win_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(TAPS)-1:0]  out_idx,
    output logic                     out_last,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(TAPS);

    state_e                  state_q, state_d;
    logic [TAPS*DATA_W-1:0]  win_q;
    logic [CNT_W-1:0]        cnt;
    logic                    at_last;
    logic                    accept;
    logic                    load;

    assign busy      = (state_q == SEND);
    assign out_valid = busy;
    assign out_idx   = cnt;
    assign out_last  = busy && at_last;
    assign accept    = out_valid && out_ready;
    // The last accepted beat frees the window register in the same cycle, so a
    // waiting window can be loaded without a bubble.
    assign win_ready = rst_n && ((state_q == IDLE) || (accept && out_last));
    assign load      = win_valid && win_ready;

    tap_cnt #(
        .TAPS (TAPS)
    ) u_tap_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (accept),
        .clr     (load),
        .cnt     (cnt),
        .at_last (at_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (load) state_d = SEND;
            SEND: if (accept && at_last) state_d = load ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                win_q <= win_data;
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (busy) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                if (cnt == CNT_W'(k)) begin
                    out_data = win_q[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_win_tx.sv
// Directed self-checking bench for conv_win_tx with hand-computed tap sequences.
module tb_conv_win_tx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TAPS   = 9;

    logic                    clk;
    logic                    rst_n;
    logic                    win_valid;
    logic                    win_ready;
    logic [TAPS*DATA_W-1:0]  win_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [3:0]              out_idx;
    logic                    out_last;
    logic                    busy;

    int checks;
    int failures;

    conv_win_tx #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TAPS*DATA_W-1:0] mk_win(input logic [7:0] base);
        logic [TAPS*DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = base + 8'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; win_valid = 1'b1; win_data = mk_win(8'h40); out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (win_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00
                || out_idx !== 4'd0 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold c=%0d: got rdy=%b v=%b busy=%b d=%h idx=%0d last=%b want 0,0,0,00,0,0",
                         c, win_ready, out_valid, busy, out_data, out_idx, out_last);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (win_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", win_ready);
        end
        tick();
        win_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== 8'h40 + 8'(k)) begin
                failures++;
                $display("FAIL reset_first_window k=%0d: got v=%b idx=%0d d=%h want 1,%0d,%h",
                         k, out_valid, out_idx, out_data, k, 8'h40 + 8'(k));
            end
            tick();
        end
    endtask

    task automatic test_single();
        win_valid = 1'b1; win_data = mk_win(8'h10); out_ready = 1'b1;
        #1;
        checks++;
        if (win_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got rdy=%b v=%b want 1,0", win_ready, out_valid);
        end
        tick();
        win_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k) || out_idx !== 4'(k)
                || out_last !== (k == 8) || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_beat k=%0d: got v=%b d=%h idx=%0d last=%b busy=%b want 1,%h,%0d,%b,1",
                         k, out_valid, out_data, out_idx, out_last, busy, 8'h10 + 8'(k), k, k == 8);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_end: got v=%b busy=%b want 0,0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        win_valid = 1'b1; win_data = mk_win(8'h01); out_ready = 1'b1;
        tick();
        win_data = mk_win(8'h21);
        for (int i = 0; i < 18; i++) begin
            #1;
            exp = (i < 9) ? 8'h01 + 8'(i) : 8'h21 + 8'(i - 9);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_idx !== 4'(i % 9)
                || win_ready !== (i == 8 || i == 17)) begin
                failures++;
                $display("FAIL b2b_beat i=%0d: got v=%b d=%h idx=%0d rdy=%b want 1,%h,%0d,%b",
                         i, out_valid, out_data, out_idx, win_ready, exp, i % 9, i == 8 || i == 17);
            end
            tick();
            if (i == 8) win_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int k;
        int accepted;
        k = 0;
        accepted = 0;
        win_valid = 1'b1; win_data = mk_win(8'h50); out_ready = 1'b1;
        tick();
        win_valid = 1'b0;
        for (int c = 0; c < 13; c++) begin
            out_ready = !(c >= 3 && c < 7);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== 8'h50 + 8'(k)
                || (!out_ready && win_ready !== 1'b0)) begin
                failures++;
                $display("FAIL bp_beat c=%0d: got v=%b idx=%0d d=%h rdy=%b want 1,%0d,%h",
                         c, out_valid, out_idx, out_data, win_ready, k, 8'h50 + 8'(k));
            end
            if (out_valid && out_ready) begin
                accepted++;
                k++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || accepted != 9) begin
            failures++;
            $display("FAIL bp_end: got v=%b accepted=%0d want 0,9", out_valid, accepted);
        end
    endtask

    task automatic test_mid_reset();
        win_valid = 1'b1; win_data = mk_win(8'h60); out_ready = 1'b1;
        tick();
        win_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (out_idx !== 4'd5 || out_data !== 8'h65) begin
            failures++;
            $display("FAIL midrst_pre: got idx=%0d d=%h want 5,65", out_idx, out_data);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 4'd0 || out_last !== 1'b0
            || busy !== 1'b0 || win_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_zero: got v=%b d=%h idx=%0d last=%b busy=%b rdy=%b want all 0",
                     out_valid, out_data, out_idx, out_last, busy, win_ready);
        end
        rst_n = 1'b1;
        win_valid = 1'b1; win_data = mk_win(8'h70);
        tick();
        win_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== 8'h70 + 8'(k)) begin
                failures++;
                $display("FAIL midrst_window_c k=%0d: got v=%b idx=%0d d=%h want 1,%0d,%h",
                         k, out_valid, out_idx, out_data, k, 8'h70 + 8'(k));
            end
            tick();
        end
    endtask

    task automatic test_late_win();
        win_valid = 1'b1; win_data = mk_win(8'h80); out_ready = 1'b1;
        tick();
        win_valid = 1'b0;
        tick();
        tick();
        win_valid = 1'b1; win_data = mk_win(8'h90);
        for (int k = 2; k < 9; k++) begin
            #1;
            checks++;
            if (win_ready !== (k == 8) || out_idx !== 4'(k) || out_data !== 8'h80 + 8'(k)) begin
                failures++;
                $display("FAIL late_wait k=%0d: got rdy=%b idx=%0d d=%h want %b,%0d,%h",
                         k, win_ready, out_idx, out_data, k == 8, k, 8'h80 + 8'(k));
            end
            tick();
        end
        win_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== 8'h90 + 8'(k)) begin
                failures++;
                $display("FAIL late_window k=%0d: got v=%b idx=%0d d=%h want 1,%0d,%h",
                         k, out_valid, out_idx, out_data, k, 8'h90 + 8'(k));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_end: got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        win_valid = 1'b0;
        win_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_late_win();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_win_tx.md
# conv_win_tx

Window serializer for the convolution datapath: accepts one complete 3x3 pixel window per handshake and emits it as a 9-beat stream, one tap per cycle, with valid/ready flow control. It is the transmit end of the tap-stream interface whose receive end counts 9 valid beats (0..8) per window. It sits between the line-buffer/window generator and the MAC accumulation stage.

## Interface
Parameters:
- DATA_W, 8, bits per tap
- TAPS, 9, taps per window; the counter width is $clog2(TAPS)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- win_valid  in  1  upstream window available
- win_ready  out  1  block accepts a window this cycle
- win_data  in  TAPS*DATA_W  flat window; tap k = win_data[k*DATA_W +: DATA_W], tap 0 first
- out_valid  out  1  tap beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_W  current tap value
- out_idx  out  $clog2(TAPS)  current tap index, 0..TAPS-1
- out_last  out  1  high on the beat with out_idx == TAPS-1
- busy  out  1  high while a window is loaded and not fully sent

## Operation
- States: IDLE and SEND.
- IDLE:
  - out_valid = 0 and win_ready = 1.
  - On win_valid: capture win_data into the window register, set cnt = 0, go to SEND.
- SEND:
  - out_valid = 1, out_data = tap[cnt], out_idx = cnt, out_last = (cnt == TAPS-1).
  - Beat accepted when out_valid && out_ready; then cnt increments.
  - On the accepted beat with cnt == TAPS-1, cnt wraps to 0.
    - If win_valid, the new window is captured in the same cycle and the block stays in SEND (back-to-back, no bubble).
    - Otherwise the block returns to IDLE.
- win_ready = (state == IDLE) || (out_valid && out_ready && out_last). It is a combinational function of registered state and out_ready.
- Stall: while out_ready = 0, out_data, out_idx, out_last and out_valid hold stable. The window register is never overwritten mid-window.
- busy = (state == SEND).
- No arithmetic on data. The counter never exceeds TAPS-1.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, cnt = 0, window register = 0.
  - out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, busy = 0.
  - win_ready is forced 0 while rst_n is low.
- Latency: window accepted at edge N gives tap 0 on the outputs after edge N, valid in cycle N+1.
- Throughput: with out_ready held high, exactly TAPS cycles per window with continuous out_valid across windows.
- Reset mid-window: the in-flight window is dropped. No partial beats are emitted after reset; the next window starts at tap 0.
- If win_valid arrives while in SEND and not on the last accepted beat, it is ignored (win_ready = 0). Upstream holds it.
- Simultaneous last-beat accept and new window: the new window wins and tap 0 of it is presented the next cycle.

## Structure
- Shared conv_pkg:
  - DATA_W and TAPS defaults, shared with the receiving tap counter.
  - state enum {IDLE, SEND}.
- One natural sub-module: tap_cnt, a modulo-TAPS counter.
  - Inputs: clk, rst_n, inc, clr. Outputs: cnt, at_last.
  - Reusable by the receive-side counter.
- Tap selection is a plain index mux on the window register; it needs no separate module.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with win_valid = 1 -> win_ready = 0, out_valid = 0, busy = 0 throughout. First window is accepted at the first edge with rst_n = 1.
- Single window: taps 0x10..0x18, out_ready = 1 -> 9 beats with out_data 0x10..0x18 and out_idx 0..8. out_last only on 0x18. Next cycle out_valid = 0.
- Back-to-back windows: windows A (0x01..0x09) and B (0x21..0x29) with win_valid held -> 18 consecutive out_valid cycles. win_ready pulses exactly on A's last beat. No bubble.
- Backpressure: drop out_ready for 4 cycles at tap 3 -> out_data and out_idx = 3 held stable. Stream resumes at tap 4. Total 9 accepted beats.
- Mid-window reset: assert rst_n = 0 at tap 5 -> outputs zero next cycle. A new window C then streams from tap 0 with out_idx 0..8.
- Late win_valid: present a window at tap 2 -> win_ready = 0 until the last beat. That window is captured on the tap 8 acceptance and its tap 0 appears the following cycle.
